pkt_port_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares the single 134b PHV/parser-config ingress between PORT_NUM ports.

---
 rtl/pkt_port_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_pkt_port_rr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_port_rr_arbiter.sv
// Packet-granular round-robin arbiter: forwards one whole packet (head..tail) at a time from PORT_NUM ports.
// Optional macro CONF_PRIO_EN lets parser-config heads (ethertype 16'h9006) win arbitration in IDLE.
module pkt_port_rr_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W   = $clog2(PORT_NUM),
  parameter int TIMEOUT  = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PORT_NUM-1:0]     i_pkt_valid,
  input  logic [134*PORT_NUM-1:0] i_pkt,
  output logic [PORT_NUM-1:0]     o_pkt_ready,
  input  logic                    i_ready,
  output logic                    o_pkt_valid,
  output logic [133:0]            o_pkt,
  output logic [7:0]              o_inport,
  output logic                    o_err_orphan,
  output logic                    o_err_timeout
);

  localparam int SW       = 134;
  localparam int TAG_HEAD = 132;
  localparam int TAG_TAIL = 133;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PORT_W-1:0] ptr_q, ptr_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [7:0]        wd_q, wd_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [SW-1:0]     pkt_q, pkt_d;
  logic              orphan_q, orphan_d;
  logic              timeout_q, timeout_d;

  logic [SW-1:0]       slice [PORT_NUM];
  logic [PORT_NUM-1:0] head_req;
  logic [PORT_NUM-1:0] cand;
  logic                hi_found, lo_found, sel_found;
  logic [PORT_W-1:0]   hi_port, lo_port, sel_port;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(PORT_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      slice[p]    = i_pkt[SW*p +: SW];
      head_req[p] = i_pkt_valid[p] & i_pkt[SW*p + TAG_HEAD];
    end
  end

`ifdef CONF_PRIO_EN
  logic [PORT_NUM-1:0] cfg_req;

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      cfg_req[p] = head_req[p] && (i_pkt[SW*p + 16 +: 16] == 16'h9006);
    end
  end

  assign cand = (|cfg_req) ? cfg_req : head_req;
`else
  assign cand = head_req;
`endif

  // Round-robin pick: lowest candidate at or above ptr_q, else lowest candidate below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_port  = '0;
    lo_port  = '0;
    for (int p = PORT_NUM - 1; p >= 0; p--) begin
      if (cand[p] && (PORT_W'(p) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_port  = PORT_W'(p);
      end
      if (cand[p] && (PORT_W'(p) < ptr_q)) begin
        lo_found = 1'b1;
        lo_port  = PORT_W'(p);
      end
    end
    sel_found = hi_found | lo_found;
    sel_port  = hi_found ? hi_port : lo_port;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    wd_d        = wd_q;
    pkt_valid_d = 1'b0;
    pkt_d       = pkt_q;
    orphan_d    = 1'b0;
    timeout_d   = 1'b0;
    o_pkt_ready = '0;

    case (state_q)
      ST_IDLE: begin
        for (int p = 0; p < PORT_NUM; p++) begin
          if (i_pkt_valid[p] && !i_pkt[SW*p + TAG_HEAD]) begin
            o_pkt_ready[p] = 1'b1;
            orphan_d       = 1'b1;
          end
        end
        if (sel_found) begin
          state_d = ST_SEND;
          grant_d = sel_port;
          wd_d    = '0;
        end
      end

      ST_SEND: begin
        o_pkt_ready[grant_q] = i_ready;
        if (i_pkt_valid[grant_q] && i_ready) begin
          pkt_valid_d = 1'b1;
          pkt_d       = slice[grant_q];
          wd_d        = '0;
          if (slice[grant_q][TAG_TAIL]) begin
            state_d = ST_IDLE;
            ptr_d   = next_port(grant_q);
          end
        end else if (i_ready) begin
          // Only downstream-ready cycles with a silent granted port count toward the abort.
          if (wd_q + 8'd1 == 8'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            ptr_d     = next_port(grant_q);
            wd_d      = '0;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      wd_q        <= '0;
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
      orphan_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      wd_q        <= wd_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_q       <= pkt_d;
      orphan_q    <= orphan_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_pkt_valid   = pkt_valid_q;
  assign o_pkt         = pkt_q;
  assign o_inport      = 8'(grant_q);
  assign o_err_orphan  = orphan_q;
  assign o_err_timeout = timeout_q;

endmodule

// File: tb/tb_pkt_port_rr_arbiter.sv
// Self-checking bench for pkt_port_rr_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a packet-level reference model. Honours CONF_PRIO_EN.
module tb_pkt_port_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int SW  = 134;
`ifdef CONF_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_pkt_valid;
  logic [SW*N-1:0] i_pkt;
  logic [N-1:0]    o_pkt_ready;
  logic            i_ready;
  logic            o_pkt_valid;
  logic [SW-1:0]   o_pkt;
  logic [7:0]      o_inport;
  logic            o_err_orphan;
  logic            o_err_timeout;

  always #5 i_clk = ~i_clk;

  pkt_port_rr_arbiter #(.PORT_NUM(N), .TIMEOUT(TMO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pkt_valid  (i_pkt_valid),
    .i_pkt        (i_pkt),
    .o_pkt_ready  (o_pkt_ready),
    .i_ready      (i_ready),
    .o_pkt_valid  (o_pkt_valid),
    .o_pkt        (o_pkt),
    .o_inport     (o_inport),
    .o_err_orphan (o_err_orphan),
    .o_err_timeout(o_err_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus seen by the DUT
  logic [N-1:0]  pv;
  logic [SW-1:0] sl [N];
  logic          rdy;

  // Reference model state (packet level)
  bit            m_busy;
  int            m_owner, m_ptr, m_idle;
  logic          e_ov, e_orph, e_tmo;
  logic [SW-1:0] e_pkt;
  int            e_inport;

  // Observations
  logic [N-1:0]  last_ready;
  logic [N-1:0]  acc;
  int            dut_grants[$];
  int            fwd_cnt, tmo_cnt;

  // Packet sources
  int src_pkts[N], src_len[N], src_pos[N], src_seq[N];

  typedef struct {
    logic [3:0] v;
    logic [1:0] tag;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [7:0] e_inport;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(input int p, input logic [1:0] tag, input int seq, input logic [15:0] eth);
    logic [SW-1:0] s;
    s          = '0;
    s[133:132] = tag;
    s[131:100] = 32'(seq);
    s[99:68]   = 32'(p * 7919 + seq * 104729);
    s[47:32]   = 16'(p);
    s[31:16]   = eth;
    s[15:0]    = 16'(seq) ^ 16'hBEEF;
    return s;
  endfunction

  function automatic bit is_head(input logic [SW-1:0] s);
    return (s[133:132] == 2'b01) || (s[133:132] == 2'b11);
  endfunction

  function automatic bit is_tail(input logic [SW-1:0] s);
    return (s[133:132] == 2'b10) || (s[133:132] == 2'b11);
  endfunction

  function automatic bit is_cfg(input logic [SW-1:0] s);
    return s[31:16] == 16'h9006;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
    e_ov = 0; e_orph = 0; e_tmo = 0; e_pkt = '0; e_inport = 0;
  endtask

  task automatic drive_inputs();
    i_pkt_valid = pv;
    i_ready     = rdy;
    for (int p = 0; p < N; p++) i_pkt[SW*p +: SW] = sl[p];
  endtask

  // One clock cycle: drive at negedge, check ready mid-low phase, check registered outputs after posedge.
  task automatic step();
    logic [N-1:0]  er;
    logic          n_ov, n_orph, n_tmo;
    logic [SW-1:0] n_pkt;
    bit            any_cfg;
    int            best, bestd, d;
    drive_inputs();
    #1;
    er = '0; n_ov = 0; n_orph = 0; n_tmo = 0; n_pkt = e_pkt;
    if (!m_busy) begin
      any_cfg = 0;
      for (int p = 0; p < N; p++) begin
        if (pv[p] && !is_head(sl[p])) begin
          er[p]  = 1'b1;
          n_orph = 1'b1;
        end
        if (PRIO && pv[p] && is_head(sl[p]) && is_cfg(sl[p])) any_cfg = 1;
      end
      best = -1; bestd = N;
      for (int p = 0; p < N; p++) begin
        if (pv[p] && is_head(sl[p]) && (!any_cfg || is_cfg(sl[p]))) begin
          d = (p - m_ptr + N) % N;
          if (d < bestd) begin bestd = d; best = p; end
        end
      end
      if (best >= 0) begin
        m_busy = 1; m_owner = best; e_inport = best; m_idle = 0;
      end
    end else begin
      er[m_owner] = rdy;
      if (pv[m_owner] && rdy) begin
        n_ov = 1; n_pkt = sl[m_owner]; m_idle = 0;
        if (is_tail(sl[m_owner])) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
      end else if (rdy) begin
        m_idle++;
        if (m_idle == TMO) begin
          n_tmo = 1; m_busy = 0; m_ptr = (m_owner + 1) % N; m_idle = 0;
        end
      end
    end
    check($sformatf("c%0d ready", cyc), o_pkt_ready, er);
    last_ready = o_pkt_ready;
    acc        = pv & o_pkt_ready;
    e_ov = n_ov; e_pkt = n_pkt; e_orph = n_orph; e_tmo = n_tmo;
    @(posedge i_clk);
    #1;
    check($sformatf("c%0d o_pkt_valid", cyc), o_pkt_valid, e_ov);
    check($sformatf("c%0d o_pkt", cyc), o_pkt, e_pkt);
    check($sformatf("c%0d o_inport", cyc), o_inport, e_inport);
    check($sformatf("c%0d o_err_orphan", cyc), o_err_orphan, e_orph);
    check($sformatf("c%0d o_err_timeout", cyc), o_err_timeout, e_tmo);
    if (o_pkt_valid === 1'b1) begin
      fwd_cnt++;
      if (is_head(o_pkt)) dut_grants.push_back(int'(o_inport));
    end
    if (o_err_timeout === 1'b1) tmo_cnt++;
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic src_clear();
    for (int p = 0; p < N; p++) begin
      src_pkts[p] = 0; src_len[p] = 1; src_pos[p] = 0; src_seq[p] = 0;
    end
  endtask

  function automatic bit src_busy();
    for (int p = 0; p < N; p++) if (src_pkts[p] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic src_drive();
    logic [1:0] tag;
    for (int p = 0; p < N; p++) begin
      pv[p] = (src_pkts[p] > 0);
      tag   = {src_pos[p] == src_len[p] - 1, src_pos[p] == 0};
      sl[p] = mk(p, tag, src_seq[p], 16'h0800);
    end
  endtask

  task automatic src_advance();
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        src_seq[p]++;
        src_pos[p]++;
        if (src_pos[p] == src_len[p]) begin src_pos[p] = 0; src_pkts[p]--; end
      end
    end
  endtask

  task automatic run_sources(input int max_steps);
    int n;
    n = 0;
    while (src_busy() && n < max_steps) begin
      src_drive(); step(); src_advance(); n++;
    end
    check("sources_drained", src_busy(), 0);
    pv = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    pv    = '0;
    rdy   = 1'b1;
    drive_inputs();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    src_clear();
    dut_grants.delete();
    fwd_cnt = 0;
    tmo_cnt = 0;
  endtask

  initial begin
    int n, found, stall_ov;
    logic [N-1:0] stall_acc;

    // Single-port packet, then a two-way head race that exposes the advanced pointer
    tbl[0] = '{4'b0010, 2'b01, 1'b1, 4'b0000, 1'b0, 8'd1};
    tbl[1] = '{4'b0010, 2'b01, 1'b1, 4'b0010, 1'b1, 8'd1};
    tbl[2] = '{4'b0010, 2'b00, 1'b1, 4'b0010, 1'b1, 8'd1};
    tbl[3] = '{4'b0010, 2'b10, 1'b1, 4'b0010, 1'b1, 8'd1};
    tbl[4] = '{4'b0000, 2'b00, 1'b1, 4'b0000, 1'b0, 8'd1};
    tbl[5] = '{4'b0110, 2'b01, 1'b1, 4'b0000, 1'b0, 8'd2};
    tbl[6] = '{4'b0100, 2'b11, 1'b1, 4'b0100, 1'b1, 8'd2};
    tbl[7] = '{4'b0000, 2'b00, 1'b1, 4'b0000, 1'b0, 8'd2};

    i_rst = 1'b1;
    pv    = '0;
    rdy   = 1'b1;
    for (int p = 0; p < N; p++) sl[p] = '0;
    drive_inputs();
    model_reset();
    src_clear();
    fwd_cnt = 0;
    tmo_cnt = 0;
    #3;
    check("reset o_pkt_valid", o_pkt_valid, 0);
    check("reset o_pkt", o_pkt, 0);
    check("reset o_inport", o_inport, 0);
    check("reset o_err_orphan", o_err_orphan, 0);
    check("reset o_err_timeout", o_err_timeout, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < 8; k++) begin
      pv  = tbl[k].v;
      rdy = tbl[k].rdy;
      for (int p = 0; p < N; p++) sl[p] = mk(p, tbl[k].tag, k, 16'h0800);
      step();
      check($sformatf("tbl%0d ready", k), last_ready, tbl[k].e_rdy);
      check($sformatf("tbl%0d valid", k), o_pkt_valid, tbl[k].e_ov);
      check($sformatf("tbl%0d inport", k), o_inport, tbl[k].e_inport);
      if (tbl[k].e_ov)
        check($sformatf("tbl%0d pkt", k), o_pkt, mk(int'(tbl[k].e_inport), tbl[k].tag, k, 16'h0800));
    end

    // Round-robin order: every port holds two 2-slice packets
    do_reset();
    for (int p = 0; p < N; p++) begin src_pkts[p] = 2; src_len[p] = 2; end
    run_sources(200);
    check("rr grant count", dut_grants.size(), 8);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr grant %0d", i), (dut_grants.size() > i) ? dut_grants[i] : -1, i % N);

    // Downstream stall mid-packet
    do_reset();
    src_pkts[2] = 1; src_len[2] = 6;
    n = 0;
    while (src_pos[2] < 2 && n < 20) begin src_drive(); step(); src_advance(); n++; end
    rdy = 1'b0;
    stall_acc = '0;
    stall_ov  = 0;
    for (int i = 0; i < 5; i++) begin
      src_drive(); step(); src_advance();
      stall_acc |= last_ready;
      if (o_pkt_valid === 1'b1) stall_ov++;
    end
    check("stall ready", stall_acc, 0);
    check("stall valid count", stall_ov, 0);
    rdy = 1'b1;
    run_sources(40);
    check("stall forwarded slices", fwd_cnt, 6);
    check("stall timeouts", tmo_cnt, 0);

    // Orphan drop, then watchdog abort
    do_reset();
    pv = 4'b0100;
    sl[2] = mk(2, 2'b10, 0, 16'h0800);
    step();
    check("orphan ready", last_ready, 4'b0100);
    check("orphan pulse", o_err_orphan, 1);
    pv = '0;
    step();
    check("orphan pulse width", o_err_orphan, 0);
    pv = 4'b0001;
    sl[0] = mk(0, 2'b01, 1, 16'h0800);
    step();
    step();
    pv = '0;
    n = 0;
    found = 0;
    while (found == 0 && n < 80) begin
      step();
      n++;
      if (o_err_timeout === 1'b1) found = n;
    end
    check("timeout idle cycles", found, TMO);
    pv = 4'b0011;
    sl[0] = mk(0, 2'b01, 2, 16'h0800);
    sl[1] = mk(1, 2'b01, 0, 16'h0800);
    step();
    check("grant after timeout", o_inport, 1);
    pv = '0;

    // Config-packet priority
    do_reset();
    pv = 4'b1001;
    sl[0] = mk(0, 2'b01, 0, 16'h0800);
    sl[3] = mk(3, 2'b01, 0, 16'h9006);
    step();
    check("prio grant", o_inport, PRIO ? 3 : 0);
    pv = '0;

    // Asynchronous reset in the middle of a packet
    do_reset();
    src_pkts[0] = 1; src_len[0] = 3;
    n = 0;
    while (src_pos[0] < 1 && n < 10) begin src_drive(); step(); src_advance(); n++; end
    check("pre-reset valid", o_pkt_valid, 1);
    src_drive();
    drive_inputs();
    #2;
    i_rst = 1'b1;
    #1;
    check("async rst o_pkt_valid", o_pkt_valid, 0);
    check("async rst o_pkt", o_pkt, 0);
    check("async rst o_inport", o_inport, 0);
    check("async rst o_err_orphan", o_err_orphan, 0);
    check("async rst o_err_timeout", o_err_timeout, 0);
    pv = '0;
    drive_inputs();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    src_clear();
    dut_grants.delete();
    fwd_cnt = 0;
    src_pkts[0] = 1; src_len[0] = 2;
    run_sources(20);
    check("post-reset grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);
    check("post-reset slices", fwd_cnt, 2);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pv  = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < N; p++) begin
        sl[p][31:0]     = $urandom;
        sl[p][63:32]    = $urandom;
        sl[p][95:64]    = $urandom;
        sl[p][127:96]   = $urandom;
        sl[p][133:128]  = 6'($urandom);
        if ($urandom_range(0, 3) == 0) sl[p][31:16] = 16'h9006;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
